// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad column scanner: strobes one active-low column per scan step,
// synchronises the rows and latches the code of the held key until it is released.
module keypad_scanner #(
  parameter int unsigned DIV_COUNT = 100000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] rows,
  output logic [3:0] cols,
  output logic [3:0] key_code,
  output logic       key_pressed
);

  localparam int unsigned DW = $clog2(DIV_COUNT);

  typedef enum logic {SCAN, HOLD} state_t;

  state_t        state, state_nxt;
  logic [DW-1:0] div_cnt;
  logic          tick;
  logic [3:0]    rows_m, rows_s;
  logic [1:0]    col, col_nxt;
  logic [3:0]    code_nxt;
  logic          pressed_nxt;
  logic [1:0]    hit_row;
  logic          any_row;
  logic [3:0]    map_code;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rows_m <= '1;
      rows_s <= '1;
    end else begin
      rows_m <= rows;
      rows_s <= rows_m;
    end
  end

  assign tick = (div_cnt == DW'(DIV_COUNT - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)    div_cnt <= '0;
    else if (tick) div_cnt <= '0;
    else           div_cnt <= div_cnt + 1'b1;
  end

  // Row 0 has priority when several rows of the driven column are low.
  always_comb begin
    any_row = (rows_s != 4'hF);
    if      (!rows_s[0]) hit_row = 2'd0;
    else if (!rows_s[1]) hit_row = 2'd1;
    else if (!rows_s[2]) hit_row = 2'd2;
    else                 hit_row = 2'd3;
  end

  always_comb begin
    case ({hit_row, col})
      4'b00_00: map_code = 4'h1;
      4'b00_01: map_code = 4'h2;
      4'b00_10: map_code = 4'h3;
      4'b00_11: map_code = 4'hA;
      4'b01_00: map_code = 4'h4;
      4'b01_01: map_code = 4'h5;
      4'b01_10: map_code = 4'h6;
      4'b01_11: map_code = 4'hB;
      4'b10_00: map_code = 4'h7;
      4'b10_01: map_code = 4'h8;
      4'b10_10: map_code = 4'h9;
      4'b10_11: map_code = 4'hC;
      4'b11_00: map_code = 4'hE;
      4'b11_01: map_code = 4'h0;
      4'b11_10: map_code = 4'hF;
      default:  map_code = 4'hD;
    endcase
  end

  always_comb begin
    state_nxt   = state;
    col_nxt     = col;
    code_nxt    = key_code;
    pressed_nxt = key_pressed;
    if (tick) begin
      case (state)
        SCAN: begin
          if (any_row) begin
            code_nxt    = map_code;
            pressed_nxt = 1'b1;
            state_nxt   = HOLD;
          end else begin
            col_nxt = col + 2'd1;
          end
        end
        HOLD: begin
          if (!any_row) begin
            pressed_nxt = 1'b0;
            col_nxt     = col + 2'd1;
            state_nxt   = SCAN;
          end
        end
        default: state_nxt = SCAN;
      endcase
    end
  end

  // cols is registered from the next column index so the pins never glitch.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= SCAN;
      col         <= '0;
      cols        <= 4'b1110;
      key_code    <= '0;
      key_pressed <= 1'b0;
    end else begin
      state       <= state_nxt;
      col         <= col_nxt;
      cols        <= ~(4'b0001 << col_nxt);
      key_code    <= code_nxt;
      key_pressed <= pressed_nxt;
    end
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: a physical keypad matrix drives the rows from the DUT columns,
// and a rule-level reference model predicts cols/key_code/key_pressed every clock.
module tb_keypad_scanner;

  localparam int DIV = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] rows;
  logic [3:0] cols;
  logic [3:0] key_code;
  logic       key_pressed;

  logic [15:0] pressed_v = '0;
  logic [3:0]  glitch = '0;

  int n_cmp = 0;
  int n_err = 0;

  int         m_div, m_c;
  bit         m_hold, m_kp;
  logic [3:0] m_code;
  logic [3:0] h1, h2;

  logic [3:0] key_map [16] = '{4'h1, 4'h2, 4'h3, 4'hA,
                               4'h4, 4'h5, 4'h6, 4'hB,
                               4'h7, 4'h8, 4'h9, 4'hC,
                               4'hE, 4'h0, 4'hF, 4'hD};

  keypad_scanner #(.DIV_COUNT(DIV)) dut (
    .clk        (clk),
    .reset      (reset),
    .rows       (rows),
    .cols       (cols),
    .key_code   (key_code),
    .key_pressed(key_pressed)
  );

  always #5 clk = ~clk;

  // Key (r,c) shorts row r to column c; a row reads low if any of its pressed keys sits on a driven column.
  function automatic logic [3:0] matrix(input logic [3:0] drv, input logic [15:0] p, input logic [3:0] g);
    logic [3:0] r;
    r = ~g;
    for (int ri = 0; ri < 4; ri++)
      for (int ci = 0; ci < 4; ci++)
        if (p[ri*4+ci] && !drv[ci]) r[ri] = 1'b0;
    return r;
  endfunction

  always_comb rows = matrix(cols, pressed_v, glitch);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_div = 0; m_c = 0; m_hold = 0; m_kp = 0; m_code = 4'h0;
    h1 = 4'hF; h2 = 4'hF;
  endtask

  function automatic logic [3:0] model_cols();
    logic [3:0] one;
    one = 4'b0001 << m_c;
    return ~one;
  endfunction

  task automatic step();
    logic [3:0] rnow, rs;
    bit tk;
    int r;
    @(posedge clk);
    if (reset) begin
      rnow = matrix(model_cols(), pressed_v, glitch);
      rs = h2; h2 = h1; h1 = rnow;
      tk = (m_div == DIV - 1);
      m_div = tk ? 0 : m_div + 1;
      if (tk) begin
        if (!m_hold) begin
          if (rs == 4'hF) m_c = (m_c + 1) % 4;
          else begin
            r = -1;
            for (int i = 3; i >= 0; i--) if (!rs[i]) r = i;
            m_code = key_map[r*4 + m_c];
            m_kp = 1; m_hold = 1;
          end
        end else if (rs == 4'hF) begin
          m_kp = 0; m_hold = 0;
          m_c = (m_c + 1) % 4;
        end
      end
    end
    #1;
    check("cols", cols, model_cols());
    check("key_code", key_code, m_code);
    check("key_pressed", key_pressed, m_kp);
    check("cols_onehot", $countones(~cols), 1);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic wait_kp(input logic lvl, input int bound, output int n);
    n = 0;
    while (key_pressed !== lvl && n < bound) begin
      step();
      n++;
    end
  endtask

  initial begin
    int n;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("rst_cols", cols, 4'b1110);
    check("rst_code", key_code, 4'h0);
    check("rst_kp", key_pressed, 0);
    #2 reset = 1'b1;

    // idle scan through all columns
    run(20);

    // key 8 (row 2, col 1)
    pressed_v[2*4+1] = 1'b1;
    wait_kp(1'b1, 40, n);
    check("t2_kp", key_pressed, 1);
    check("t2_code", key_code, 4'h8);
    run(8);
    check("t2_cols_frozen", cols, 4'b1101);
    pressed_v = '0;
    wait_kp(1'b0, 8, n);
    check("t2_rel_kp", key_pressed, 0);
    check("t2_rel_cols", cols, 4'b1011);
    check("t2_rel_code", key_code, 4'h8);

    // rows 0 and 3 together in col 3
    pressed_v[0*4+3] = 1'b1;
    pressed_v[3*4+3] = 1'b1;
    wait_kp(1'b1, 40, n);
    check("t3_code", key_code, 4'hA);
    pressed_v[0*4+3] = 1'b0;
    run(12);
    check("t3_hold_kp", key_pressed, 1);
    check("t3_hold_code", key_code, 4'hA);
    pressed_v = '0;
    wait_kp(1'b0, 8, n);

    // key 1 held, then a key in another column
    pressed_v[0] = 1'b1;
    wait_kp(1'b1, 40, n);
    check("t4_code", key_code, 4'h1);
    pressed_v[1*4+2] = 1'b1;
    run(20);
    check("t4_other_col_code", key_code, 4'h1);
    pressed_v = '0;
    wait_kp(1'b0, 8, n);
    run(24);
    check("t4_idle_kp", key_pressed, 0);

    // reset in the middle of a hold of key D
    pressed_v[3*4+3] = 1'b1;
    wait_kp(1'b1, 40, n);
    check("t5_code", key_code, 4'hD);
    #1 reset = 1'b0;
    #1;
    check("t5_async_cols", cols, 4'b1110);
    check("t5_async_code", key_code, 4'h0);
    check("t5_async_kp", key_pressed, 0);
    model_reset();
    #4 reset = 1'b1;
    wait_kp(1'b1, 4*DIV + 2, n);
    check("t5_redetect_kp", key_pressed, 1);
    check("t5_redetect_code", key_code, 4'hD);
    pressed_v = '0;
    wait_kp(1'b0, 8, n);

    // one-clock glitch on row 1 right after a tick
    n = 0;
    while (m_div != 0 && n < 8) begin step(); n++; end
    glitch = 4'b0010;
    step();
    glitch = '0;
    run(12);
    check("t6_glitch_kp", key_pressed, 0);

    // randomized presses, releases and glitches
    for (int it = 0; it < 40; it++) begin
      pressed_v = '0;
      pressed_v[$urandom_range(0, 15)] = 1'b1;
      if ($urandom_range(0, 1) == 1) pressed_v[$urandom_range(0, 15)] = 1'b1;
      run($urandom_range(1, 40));
      if ($urandom_range(0, 1) == 1) begin
        pressed_v[$urandom_range(0, 15)] = 1'b0;
        run($urandom_range(1, 20));
      end
      pressed_v = '0;
      if ($urandom_range(0, 3) == 0) begin
        glitch = 4'($urandom_range(0, 15));
        run($urandom_range(1, 2));
        glitch = '0;
      end
      run($urandom_range(1, 24));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish, compared %0d", n_cmp);
    $fatal(1, "timeout");
  end

endmodule
